// File: rtl/seg7_scan_n.sv
// Multiplexed hex seven-segment scanner for DIGITS digits.
// A prescaler divides CLK into digit slots. Each slot starts with a dead
// time in which every digit is off. New data is held pending and swapped
// into the display register only at a frame boundary, so a frame is never
// torn. PATTERN, DIGIT and FRAME are registered, giving one cycle of latency.
module seg7_scan_n #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int DEADTIME   = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  CLK,
   input  logic                  IN_CLR,
   input  logic [4*DIGITS-1:0]   DATA,
   input  logic [DIGITS-1:0]     DP,
   input  logic [DIGITS-1:0]     BLANK,
   input  logic                  LZ_EN,
   input  logic                  LOAD,
   output logic [7:0]            PATTERN,
   output logic [DIGITS-1:0]     DIGIT,
   output logic                  FRAME
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [7:0]        PAT_INV    = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] DIG_INV    = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   // Scan timing state
   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   // Holding register written by LOAD, display register read by the scanner
   logic [4*DIGITS-1:0]   hold_data_q, hold_data_d;
   logic [DIGITS-1:0]     hold_dp_q, hold_dp_d;
   logic [DIGITS-1:0]     hold_blank_q, hold_blank_d;
   logic                  pend_q, pend_d;
   logic [4*DIGITS-1:0]   disp_data_q, disp_data_d;
   logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
   logic [DIGITS-1:0]     disp_blank_q, disp_blank_d;
   // Output registers
   logic [7:0]            pattern_q, pattern_d;
   logic [DIGITS-1:0]     digit_q, digit_d;
   logic                  frame_q, frame_d;

   logic                  tick;
   logic                  boundary;
   logic                  in_dead;
   logic [DIGITS-1:0]     supp_vec;
   logic [DIGITS:1]       nz_up;

   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic                  cur_supp;
   logic [DIGITS-1:0]     dig_onehot;
   logic [7:0]            pat_raw;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      logic [6:0] f;
      case (n)
         4'h0:    f = 7'h3F;
         4'h1:    f = 7'h06;
         4'h2:    f = 7'h5B;
         4'h3:    f = 7'h4F;
         4'h4:    f = 7'h66;
         4'h5:    f = 7'h6D;
         4'h6:    f = 7'h7D;
         4'h7:    f = 7'h07;
         4'h8:    f = 7'h7F;
         4'h9:    f = 7'h6F;
         4'hA:    f = 7'h77;
         4'hB:    f = 7'h7C;
         4'hC:    f = 7'h39;
         4'hD:    f = 7'h5E;
         4'hE:    f = 7'h79;
         default: f = 7'h71;
      endcase
      return f;
   endfunction

   assign tick     = (presc_q == PRESC_LAST);
   assign boundary = tick && (idx_q == IDX_LAST);

   // Dead time only exists when DEADTIME > 0; avoids a constant compare otherwise
   generate
      if (DEADTIME > 0) begin : g_dead
         assign in_dead = (presc_q < PW'(DEADTIME));
      end else begin : g_nodead
         assign in_dead = 1'b0;
      end
   endgenerate

   // Leading-zero suppression: nz_up[i] is set when any nibble at or above i is nonzero
   assign nz_up[DIGITS] = 1'b0;
   assign supp_vec[0]   = 1'b0;
   generate
      for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
         assign nz_up[gi]    = (|disp_data_q[4*gi +: 4]) | nz_up[gi+1];
         assign supp_vec[gi] = LZ_EN && !nz_up[gi];
      end
   endgenerate

   // Next state for prescaler, digit index, holding and display registers
   always_comb begin
      presc_d      = tick ? '0 : presc_q + 1'b1;
      idx_d        = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      hold_data_d  = hold_data_q;
      hold_dp_d    = hold_dp_q;
      hold_blank_d = hold_blank_q;
      pend_d       = pend_q;
      disp_data_d  = disp_data_q;
      disp_dp_d    = disp_dp_q;
      disp_blank_d = disp_blank_q;
      if (boundary && LOAD) begin
         // A load landing on the boundary goes straight to the display
         disp_data_d  = DATA;
         disp_dp_d    = DP;
         disp_blank_d = BLANK;
         pend_d       = 1'b0;
      end else if (boundary && pend_q) begin
         disp_data_d  = hold_data_q;
         disp_dp_d    = hold_dp_q;
         disp_blank_d = hold_blank_q;
         pend_d       = 1'b0;
      end else if (LOAD) begin
         hold_data_d  = DATA;
         hold_dp_d    = DP;
         hold_blank_d = BLANK;
         pend_d       = 1'b1;
      end
   end

   // Select the current digit's data and build the registered output values
   always_comb begin
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      cur_supp   = 1'b0;
      dig_onehot = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib       = disp_data_q[4*i +: 4];
            cur_dp        = disp_dp_q[i];
            cur_blank     = disp_blank_q[i];
            cur_supp      = supp_vec[i];
            dig_onehot[i] = 1'b1;
         end
      end
      pat_raw   = cur_blank ? 8'h00 : {cur_dp, (cur_supp ? 7'h00 : hex_font(cur_nib))};
      pattern_d = pat_raw ^ PAT_INV;
      digit_d   = (in_dead ? '0 : dig_onehot) ^ DIG_INV;
      frame_d   = boundary;
   end

   // State and output registers; reset forces outputs inactive
   always_ff @(posedge CLK) begin
      if (IN_CLR) begin
         presc_q      <= '0;
         idx_q        <= '0;
         hold_data_q  <= '0;
         hold_dp_q    <= '0;
         hold_blank_q <= '0;
         pend_q       <= 1'b0;
         disp_data_q  <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '0;
         pattern_q    <= PAT_INV;
         digit_q      <= DIG_INV;
         frame_q      <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         hold_data_q  <= hold_data_d;
         hold_dp_q    <= hold_dp_d;
         hold_blank_q <= hold_blank_d;
         pend_q       <= pend_d;
         disp_data_q  <= disp_data_d;
         disp_dp_q    <= disp_dp_d;
         disp_blank_q <= disp_blank_d;
         pattern_q    <= pattern_d;
         digit_q      <= digit_d;
         frame_q      <= frame_d;
      end
   end

   assign PATTERN = pattern_q;
   assign DIGIT   = digit_q;
   assign FRAME   = frame_q;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Scoreboard bench for seg7_scan_n. Two instances: the main one
// (4 digits, 4 cycles/slot, 1 dead cycle, active-low) and an edge one
// (1 digit, no dead time, active-high). The driver pushes the expected
// registered output for every clock edge; a monitor pops and compares.
module tb_seg7_scan_n;

   typedef struct packed {
      logic [7:0] pat;
      logic [7:0] dig;
      logic       frm;
   } out_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance stimulus
   logic        clr = 1'b1;
   logic [15:0] data_m = '0;
   logic [3:0]  dp_m = '0;
   logic [3:0]  blank_m = '0;
   logic        lz_m = 1'b0;
   logic        load_m = 1'b0;
   logic [7:0]  pat_m;
   logic [3:0]  dig_m;
   logic        frm_m;

   // Edge instance stimulus
   logic [3:0]  data_e = '0;
   logic        dp_e = 1'b0;
   logic        blank_e = 1'b0;
   logic        lz_e = 1'b0;
   logic        load_e = 1'b0;
   logic [7:0]  pat_e;
   logic        dig_e;
   logic        frm_e;

   seg7_scan_n #(.DIGITS(4), .SCAN_DIV(4), .DEADTIME(1), .ACTIVE_LOW(1)) u_main (
      .CLK(clk), .IN_CLR(clr), .DATA(data_m), .DP(dp_m), .BLANK(blank_m),
      .LZ_EN(lz_m), .LOAD(load_m), .PATTERN(pat_m), .DIGIT(dig_m), .FRAME(frm_m));

   seg7_scan_n #(.DIGITS(1), .SCAN_DIV(4), .DEADTIME(0), .ACTIVE_LOW(0)) u_edge (
      .CLK(clk), .IN_CLR(clr), .DATA(data_e), .DP(dp_e), .BLANK(blank_e),
      .LZ_EN(lz_e), .LOAD(load_e), .PATTERN(pat_e), .DIGIT(dig_e), .FRAME(frm_e));

   logic [7:0] font_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   out_t q_m[$];
   out_t q_e[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state: cycles since reset plus shown/held contents
   int          t_m = 0;
   logic [15:0] dd_m = '0, hd_m = '0;
   logic [3:0]  ddp_m = '0, hdp_m = '0, dbl_m = '0, hbl_m = '0;
   bit          pend_m = 1'b0;
   int          t_e = 0;
   logic [3:0]  dd_e = '0, hd_e = '0;
   logic        ddp_e = 1'b0, hdp_e = 1'b0, dbl_e = 1'b0, hbl_e = 1'b0;
   bit          pend_e = 1'b0;

   // Output expected after the next edge, from the display rules applied to the model state
   function automatic out_t model_out(int d, int s, int dt, int al, int t,
                                      logic [31:0] data, logic [7:0] dp, logic [7:0] blank,
                                      bit lz, bit rst);
      out_t o;
      int   presc, idx;
      logic [7:0] pat, dig, mask;
      mask = 8'((1 << d) - 1);
      if (rst) begin
         o.pat = (al != 0) ? 8'hFF : 8'h00;
         o.dig = (al != 0) ? mask : 8'h00;
         o.frm = 1'b0;
         return o;
      end
      presc = t % s;
      idx   = (t / s) % d;
      pat   = {dp[idx], font_tbl[4'(data >> (4 * idx))][6:0]};
      if (lz && idx > 0 && ((data >> (4 * idx)) == 0)) pat[6:0] = 7'h00;
      if (blank[idx]) pat = 8'h00;
      dig = (presc < dt) ? 8'h00 : (8'd1 << idx);
      if (al != 0) begin
         pat = ~pat;
         dig = ~dig & mask;
      end
      o.pat = pat;
      o.dig = dig;
      o.frm = ((t % (s * d)) == (s * d - 1));
      return o;
   endfunction

   // One clock: push expectations, advance the models, wait for the edge
   task automatic step();
      bit bnd;
      load_e  = ($urandom_range(0, 4) == 0);
      data_e  = 4'($urandom);
      dp_e    = 1'($urandom);
      blank_e = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) lz_e = ~lz_e;
      q_m.push_back(model_out(4, 4, 1, 1, t_m, 32'(dd_m), 8'(ddp_m), 8'(dbl_m), lz_m, clr));
      q_e.push_back(model_out(1, 4, 0, 0, t_e, 32'(dd_e), 8'(ddp_e), 8'(dbl_e), lz_e, clr));
      if (clr) begin
         t_m = 0; dd_m = '0; ddp_m = '0; dbl_m = '0; hd_m = '0; hdp_m = '0; hbl_m = '0; pend_m = 0;
         t_e = 0; dd_e = '0; ddp_e = 0;  dbl_e = 0;  hd_e = '0; hdp_e = 0;  hbl_e = 0;  pend_e = 0;
      end else begin
         bnd = ((t_m % 16) == 15);
         if (load_m && bnd) begin
            dd_m = data_m; ddp_m = dp_m; dbl_m = blank_m; pend_m = 0;
         end else if (bnd && pend_m) begin
            dd_m = hd_m; ddp_m = hdp_m; dbl_m = hbl_m; pend_m = 0;
         end else if (load_m) begin
            hd_m = data_m; hdp_m = dp_m; hbl_m = blank_m; pend_m = 1;
         end
         t_m++;
         bnd = ((t_e % 4) == 3);
         if (load_e && bnd) begin
            dd_e = data_e; ddp_e = dp_e; dbl_e = blank_e; pend_e = 0;
         end else if (bnd && pend_e) begin
            dd_e = hd_e; ddp_e = hdp_e; dbl_e = hbl_e; pend_e = 0;
         end else if (load_e) begin
            hd_e = data_e; hdp_e = dp_e; hbl_e = blank_e; pend_e = 1;
         end
         t_e++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic goto_phase(int p);
      for (int i = 0; i < 16 && (t_m % 16) != p; i++) step();
   endtask

   task automatic do_load(logic [15:0] d, logic [3:0] p, logic [3:0] b);
      data_m = d; dp_m = p; blank_m = b; load_m = 1'b1;
      $display("load  t=%0t phase=%0d data=%h dp=%b blank=%b lz=%b", $time, t_m % 16, d, p, b, lz_m);
      step();
      load_m = 1'b0;
   endtask

   // Monitor: compare both instances' outputs once per cycle, away from the edge
   initial begin
      out_t exp_o, act_o;
      forever begin
         @(negedge clk);
         if (q_m.size() == 0 || q_e.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_underflow t=%0t main=%0d edge=%0d entries", $time, q_m.size(), q_e.size());
         end else begin
            exp_o = q_m.pop_front();
            act_o = '{pat: pat_m, dig: {4'b0, dig_m}, frm: frm_m};
            n_cmp++;
            if (act_o !== exp_o) begin
               n_err++;
               $display("FAIL main_out t=%0t got pat=%h dig=%b frame=%b exp pat=%h dig=%b frame=%b",
                        $time, act_o.pat, act_o.dig[3:0], act_o.frm, exp_o.pat, exp_o.dig[3:0], exp_o.frm);
            end
            exp_o = q_e.pop_front();
            act_o = '{pat: pat_e, dig: {7'b0, dig_e}, frm: frm_e};
            n_cmp++;
            if (act_o !== exp_o) begin
               n_err++;
               $display("FAIL edge_out t=%0t got pat=%h dig=%b frame=%b exp pat=%h dig=%b frame=%b",
                        $time, act_o.pat, act_o.dig[0], act_o.frm, exp_o.pat, exp_o.dig[0], exp_o.frm);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog t=%0t bench did not complete", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset and idle: display shows zeros
      clr = 1'b1;
      run(2);
      clr = 1'b0;
      run(20);
      // Scan of 1FA5
      goto_phase(6);
      do_load(16'h1FA5, 4'b0000, 4'b0000);
      run(36);
      // Mid-frame load stays pending until the boundary
      goto_phase(5);
      do_load(16'h1234, 4'b0000, 4'b0000);
      run(24);
      // Pending load overtaken by a load coincident with the boundary
      goto_phase(3);
      do_load(16'h9ABC, 4'b0101, 4'b0000);
      goto_phase(15);
      do_load(16'h5678, 4'b0000, 4'b0000);
      run(20);
      // Leading-zero suppression with dp on a suppressed digit
      lz_m = 1'b1;
      do_load(16'h0070, 4'b1000, 4'b0000);
      run(36);
      do_load(16'h0000, 4'b0000, 4'b0000);
      run(36);
      lz_m = 1'b0;
      // Forced blank overrides dp
      do_load(16'hC3E8, 4'b1111, 4'b0010);
      run(36);
      // Reset mid-frame at index 2 with a load pending
      do_load(16'h4321, 4'b0000, 4'b0000);
      goto_phase(9);
      $display("reset t=%0t phase=%0d", $time, t_m % 16);
      clr = 1'b1;
      step();
      clr = 1'b0;
      run(36);
      // Load coincident with reset is ignored
      clr = 1'b1;
      do_load(16'hFFFF, 4'b1111, 4'b0000);
      clr = 1'b0;
      run(36);
      // Randomized traffic
      for (int k = 0; k < 900; k++) begin
         clr     = ($urandom_range(0, 199) == 0);
         load_m  = ($urandom_range(0, 9) == 0);
         data_m  = 16'($urandom);
         if ($urandom_range(0, 2) == 0) data_m = data_m >> (4 * $urandom_range(1, 4));
         dp_m    = 4'($urandom);
         blank_m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 49) == 0) lz_m = ~lz_m;
         if (clr) $display("reset t=%0t phase=%0d", $time, t_m % 16);
         else if (load_m) $display("load  t=%0t phase=%0d data=%h dp=%b blank=%b lz=%b",
                                   $time, t_m % 16, data_m, dp_m, blank_m, lz_m);
         step();
      end
      clr = 1'b0;
      load_m = 1'b0;
      run(20);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_n.md
SEG7_SCAN_N -- requirements
Module: seg7_scan_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4, the number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, the CLK cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter DEADTIME, default 2, the cycles at the start of each slot with all digits off (legal 0..SCAN_DIV-1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 means PATTERN and DIGIT are driven active-low, 0 means active-high.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port IN_CLR, input, 1 bit, the reset; synchronous and active-high.
REQ-007 SHALL have port DATA, input, 4*DIGITS bits, one hex nibble per digit; DATA[3:0] is digit 0, the rightmost digit.
REQ-008 SHALL have port DP, input, DIGITS bits, the decimal point per digit (1 = lit).
REQ-009 SHALL have port BLANK, input, DIGITS bits, a forced blank per digit (1 = all segments off).
REQ-010 SHALL have port LZ_EN, input, 1 bit, the leading-zero suppression enable.
REQ-011 SHALL have port LOAD, input, 1 bit, a single-cycle strobe that captures DATA, DP and BLANK.
REQ-012 SHALL have port PATTERN, output, 8 bits, the segments: bit0=a ... bit6=g, bit7=dp.
REQ-013 SHALL have port DIGIT, output, DIGITS bits, the digit enables, at most one active.
REQ-014 SHALL have port FRAME, output, 1 bit, a one-cycle pulse when a new frame begins.

Function
REQ-015 SHALL count a prescaler 0..SCAN_DIV-1, wrapping; a "tick" is the cycle in which the prescaler equals SCAN_DIV-1.
REQ-016 SHALL advance the digit index 0 -> 1 -> ... -> DIGITS-1 -> 0 on each tick; a frame boundary is a tick while index = DIGITS-1.
REQ-017 SHALL capture DATA/DP/BLANK into a holding register and set a pending flag on LOAD; a later LOAD before the boundary overwrites the holding register.
REQ-018 SHALL copy the holding register into the display register at a frame boundary while pending = 1, then clear pending; the display never changes mid-frame.
REQ-019 SHALL, when LOAD coincides with a frame boundary, copy the new DATA/DP/BLANK straight into the display register and leave pending = 0.
REQ-020 SHALL encode the nibble with the active-high a-g hex font 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-021 SHALL, when LZ_EN = 1, blank the a-g segments of every digit above the most significant nonzero nibble; digit 0 is never suppressed and a suppressed digit still shows its DP bit.
REQ-022 SHALL force PATTERN to all segments off, dp included, for a digit with BLANK = 1; BLANK overrides DP and the font.
REQ-023 SHALL hold DIGIT all inactive while prescaler < DEADTIME (anti-ghosting) and show the one-hot enable of the current index otherwise; PATTERN remains valid in deadtime.
REQ-024 SHALL register PATTERN, DIGIT and FRAME, so outputs in cycle t reflect prescaler/index/display state of cycle t-1 (latency 1).
REQ-025 SHALL assert FRAME for exactly one cycle, in the cycle after each frame boundary tick (coincident with any display-register update taking effect on outputs).
REQ-026 SHALL, when ACTIVE_LOW = 1, invert all PATTERN and DIGIT bits at the output registers; ACTIVE_LOW does not affect FRAME.

Reset
REQ-027 SHALL, while IN_CLR = 1 at a clock edge, clear the prescaler, index, holding register, display register and pending flag to 0.
REQ-028 SHALL, during and after reset, drive PATTERN and DIGIT inactive (0xFF and all-1 if ACTIVE_LOW = 1, else 0) and FRAME = 0 until the first post-reset cycle is registered.
REQ-029 SHALL, on reset asserted mid-frame, abandon any pending LOAD and restart at index 0, prescaler 0; a LOAD coincident with IN_CLR is ignored.
REQ-030 SHALL, after reset with no LOAD, display 0000 (or a single 0 on digit 0 when LZ_EN = 1).

Verification (DIGITS=4, SCAN_DIV=4, DEADTIME=1, ACTIVE_LOW=1 unless noted)
REQ-031 SHALL check the scan: LOAD DATA=16'h1FA5, DP=0, BLANK=0, wait one frame -> DIGIT sequence 1111,1110x3,1111,1101x3,... and PATTERN ~5A->A5 (digit0 '5' = 6D, so PATTERN 92), 'A' 88, 'F' 8E, '1' F9.
REQ-032 SHALL check tear-free update: LOAD 16'h1234 mid-frame -> PATTERN keeps the old values until the cycle FRAME = 1, then shows new digits; pending LOAD at the boundary with LOAD coincident -> direct update.
REQ-033 SHALL check LZ_EN=1 with DATA=16'h0070 and DP=4'b1000 -> digit3 PATTERN 7F (dp only), digit2 FF, digit1 F8 ('7'), digit0 C0 ('0').
REQ-034 SHALL check BLANK=4'b0010 with DP=4'b1111 -> digit1 PATTERN FF while the others show their font with dp lit.
REQ-035 SHALL check reset mid-frame after LOAD: IN_CLR=1 one cycle at index 2 -> next cycle outputs FF/1111, FRAME=0; scan restarts at digit 0, display 0000.
REQ-036 SHALL check the edge parameters ACTIVE_LOW=0, DIGITS=1, DEADTIME=0 -> DIGIT constantly 1, FRAME every 4 cycles, PATTERN uninverted.
